// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse-train generator.
package pulse_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_PERIOD   = 2;
  localparam int RESET_PERIOD = 2;
  localparam int RESET_HIGH   = 1;

endpackage

// File: rtl/pulse_width_generator.sv
// Programmable pulse-train generator with double-buffered period/high-time
// configuration so that reconfiguration only lands on period boundaries.
module pulse_width_generator
  import pulse_gen_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_high,
  input  logic [NW-1:0] cfg_num,
  input  logic          start,
  input  logic          stop,
  output logic          pulse_out,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pulse_idx
);

  state_t        state;
  logic [W-1:0]  pend_period;
  logic [W-1:0]  pend_high;
  logic [W-1:0]  act_period;
  logic [W-1:0]  act_high;
  logic [W-1:0]  cnt;
  logic [NW-1:0] remaining;
  logic          finite;
  logic          stop_req;

  logic [W-1:0]  pend_period_eff;
  logic [W-1:0]  cnt_next;
  logic          at_boundary;
  logic          train_end;

  // Period is clamped once when it moves into the active set.
  always_comb begin
    pend_period_eff = (pend_period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : pend_period;
    cnt_next        = cnt + W'(1);
    at_boundary     = (cnt == act_period - W'(1));
    train_end       = (finite && (remaining == NW'(1))) || stop_req || stop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_period <= W'(RESET_PERIOD);
      pend_high   <= W'(RESET_HIGH);
      act_period  <= W'(RESET_PERIOD);
      act_high    <= W'(RESET_HIGH);
      cnt         <= '0;
      remaining   <= '0;
      finite      <= 1'b0;
      stop_req    <= 1'b0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (cfg_wr) begin
        pend_period <= cfg_period;
        pend_high   <= cfg_high;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state      <= RUN;
            busy       <= 1'b1;
            act_period <= pend_period_eff;
            act_high   <= pend_high;
            cnt        <= '0;
            pulse_idx  <= '0;
            remaining  <= cfg_num;
            finite     <= (cfg_num != '0);
            stop_req   <= 1'b0;
            pulse_out  <= (pend_high != '0);
          end
        end

        RUN: begin
          if (stop) begin
            stop_req <= 1'b1;
          end
          // The output is registered, so it is computed from the cnt of the next cycle.
          if (at_boundary) begin
            pulse_idx <= pulse_idx + NW'(1);
            cnt       <= '0;
            if (train_end) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pulse_out <= 1'b0;
              stop_req  <= 1'b0;
            end else begin
              act_period <= pend_period_eff;
              act_high   <= pend_high;
              pulse_out  <= (pend_high != '0);
              if (finite) begin
                remaining <= remaining - NW'(1);
              end
            end
          end else begin
            cnt       <= cnt_next;
            pulse_out <= (cnt_next < act_high);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_generator.sv
// Scoreboard bench for pulse_width_generator: expected cycles are queued from a timing model.
module tb_pulse_width_generator;

  localparam int W  = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_high;
  logic [NW-1:0] cfg_num;
  logic          start;
  logic          stop;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [NW-1:0] pulse_idx;

  pulse_width_generator #(.W(W), .NW(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_num    (cfg_num),
    .start      (start),
    .stop       (stop),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          po;
    logic          busy;
    logic          done;
    logic [NW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void push_entry(input logic po, input logic b, input logic d, input int idx);
    exp_t e;
    e.po   = po;
    e.busy = b;
    e.done = d;
    e.idx  = NW'(idx);
    exp_q.push_back(e);
  endfunction

  // One full period: high for the first h cycles, period clamped to at least 2.
  function automatic void push_period(input int p, input int h, input int idx);
    int pe;
    pe = (p < 2) ? 2 : p;
    for (int j = 0; j < pe; j++) push_entry(j < h, 1'b1, 1'b0, idx);
  endfunction

  function automatic void push_end(input int idx);
    push_entry(1'b0, 1'b0, 1'b1, idx);
  endfunction

  function automatic void push_idle(input int idx, input int n);
    for (int j = 0; j < n; j++) push_entry(1'b0, 1'b0, 1'b0, idx);
  endfunction

  function automatic void push_train(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) push_period(p, h, k);
    push_end(n);
  endfunction

  // Optionally writes the config, then pulses start so the next negedge samples cycle T+1.
  task automatic start_train(input int p, input int h, input int n, input bit wr);
    @(negedge clk);
    if (wr) begin
      cfg_wr     = 1'b1;
      cfg_period = W'(p);
      cfg_high   = W'(h);
      @(negedge clk);
      cfg_wr = 1'b0;
    end
    start   = 1'b1;
    cfg_num = NW'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pulse_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulse_out got=%b want=0", pulse_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++;
    if (pulse_idx !== '0) begin failures++; $display("[TB] FAIL reset_idx got=%0d want=0", pulse_idx); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e, obs;
    int   n;
    start_train(10, 3, 4, 1'b1);
    push_train(10, 3, 4);
    push_idle(4, 3);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {pulse_out, busy, done, pulse_idx};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL basic cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                 i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
      end
    end
  endtask

  task automatic test_clamp();
    exp_t e, obs;
    int   n;
    int   cp[3] = '{1, 5, 5};
    int   ch[3] = '{1, 0, 9};
    int   cn[3] = '{3, 2, 2};
    for (int t = 0; t < 3; t++) begin
      start_train(cp[t], ch[t], cn[t], 1'b1);
      push_train(cp[t], ch[t], cn[t]);
      push_idle(cn[t], 2);
      n = exp_q.size();
      for (int i = 1; i <= n; i++) begin
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {pulse_out, busy, done, pulse_idx};
        checks++;
        if (obs !== e) begin
          failures++;
          $display("[TB] FAIL clamp P=%0d H=%0d cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                   cp[t], ch[t], i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, obs;
    int   n;
    start_train(4, 2, 2, 1'b1);
    push_train(4, 2, 2);
    push_train(4, 2, 1);
    push_idle(1, 2);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {pulse_out, busy, done, pulse_idx};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                 i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
      end
      if (i == 9) begin start = 1'b1; cfg_num = NW'(1); end
      if (i == 10) start = 1'b0;
    end
  endtask

  // Pass 0 writes mid-period (cnt=3); pass 1 writes in the boundary cycle.
  task automatic test_reconfig();
    exp_t e, obs;
    int   n, wr_at, stop_at;
    for (int pass = 0; pass < 2; pass++) begin
      start_train(8, 4, 0, 1'b1);
      push_period(8, 4, 0);
      if (pass == 1) push_period(8, 4, 1);
      push_period(6, 2, pass + 1);
      if (pass == 0) push_period(6, 2, 2);
      push_end(3);
      push_idle(3, 2);
      wr_at   = (pass == 0) ? 4 : 8;
      stop_at = (pass == 0) ? 16 : 18;
      n = exp_q.size();
      for (int i = 1; i <= n; i++) begin
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {pulse_out, busy, done, pulse_idx};
        checks++;
        if (obs !== e) begin
          failures++;
          $display("[TB] FAIL reconfig pass %0d cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                   pass, i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
        end
        if (i == wr_at) begin cfg_wr = 1'b1; cfg_period = W'(6); cfg_high = W'(2); end
        if (i == wr_at + 1) cfg_wr = 1'b0;
        if (i == stop_at) stop = 1'b1;
        if (i == stop_at + 1) stop = 1'b0;
      end
    end
  endtask

  task automatic test_stop();
    exp_t e, obs;
    int   n;
    start_train(10, 5, 0, 1'b1);
    push_period(10, 5, 0);
    push_end(1);
    push_idle(1, 5);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {pulse_out, busy, done, pulse_idx};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL stop cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                 i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
      end
      if (i == 3) stop = 1'b1;
      if (i == 4) stop = 1'b0;
      if (i == 12) begin start = 1'b1; stop = 1'b1; cfg_num = NW'(1); end
      if (i == 13) begin start = 1'b0; stop = 1'b0; end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e, obs;
    int   n;
    start_train(7, 5, 0, 1'b1);
    push_entry(1'b1, 1'b1, 1'b0, 0);
    push_entry(1'b1, 1'b1, 1'b0, 0);
    push_idle(0, 2);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {pulse_out, busy, done, pulse_idx};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL reset_midrun cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                 i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
      end
      if (i == 2) rst = 1'b1;
      if (i == 3) rst = 1'b0;
    end
    // Without a cfg_wr the train must use the reset defaults P=2, H=1.
    start_train(0, 0, 2, 1'b0);
    push_train(2, 1, 2);
    push_idle(2, 2);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {pulse_out, busy, done, pulse_idx};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL reset_defaults cycle %0d got po=%b busy=%b done=%b idx=%0d want po=%b busy=%b done=%b idx=%0d",
                 i, obs.po, obs.busy, obs.done, obs.idx, e.po, e.busy, e.done, e.idx);
      end
    end
  endtask

  // Bench-side period measurement: cycles between successive rising edges.
  task automatic test_loopback();
    int   nrise, last;
    logic prev, saw_done;
    int   meas[$];
    nrise = 0;
    last  = 0;
    prev  = 1'b0;
    start_train(1000, 250, 0, 1'b1);
    for (int i = 1; i <= 8300 && nrise < 9; i++) begin
      @(negedge clk);
      if (pulse_out && !prev) begin
        if (nrise > 0) meas.push_back(i - last);
        last = i;
        nrise++;
      end
      prev = pulse_out;
    end
    foreach (meas[k]) begin
      checks++;
      if (meas[k] != 1000) begin
        failures++;
        $display("[TB] FAIL loopback period %0d got=%0d want=1000", k, meas[k]);
      end
    end
    checks++;
    if (nrise < 9) begin
      failures++;
      $display("[TB] FAIL loopback_edges got=%0d want=9", nrise);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 1100 && !saw_done; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (!saw_done || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loopback_stop got done_seen=%b busy=%b want done_seen=1 busy=0", saw_done, busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_wr     = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_num    = '0;
    start      = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_reconfig();
    test_stop();
    test_reset_midrun();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
